// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Function : Hazard control for an in-order pipeline. It resolves load-use
//            stalls, branch/jalr mispredict flushes and multicycle mul/div
//            holds into PC and pipeline-register enables and flushes. It
//            also keeps saturating stall and flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PL_stall,
    input  logic             PL_flush,
    input  logic [31:0]      pc_rollback_ex_o,
    input  logic             md_req,
    input  logic             md_done,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [31:0]      pc_redirect_target,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_MD_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_pc_en;
    logic w_redirect;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_stall_evt;
    logic w_flush_evt;

    // Decode the current state and requests into control outputs, next state and counter events.
    always_comb begin
        w_next        = ST_RUN;
        w_pc_en       = 1'b1;
        w_redirect    = 1'b0;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_stall_evt   = 1'b0;
        w_flush_evt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (PL_flush) begin
                    // Mispredict wins: younger stall/md requests are squashed.
                    w_redirect    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_flush_evt   = 1'b1;
                    w_next        = ST_RECOVER;
                end else if (PL_stall) begin
                    // Freeze fetch/decode and push a bubble into EX.
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_stall_evt   = 1'b1;
                end else if (md_req) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    w_stall_evt = 1'b1;
                    w_next      = ST_MD_WAIT;
                end
            end
            ST_RECOVER: begin
                // Redirected fetch is still in flight in the instruction memory.
                w_if_id_flush = 1'b1;
            end
            ST_MD_WAIT: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_stall_evt = 1'b1;
                if (md_done) begin
                    // Let the mul/div result advance and bubble behind it.
                    w_id_ex_flush = 1'b1;
                end else begin
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    w_next      = ST_MD_WAIT;
                end
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
    end

    // State register; reset aborts any recover or md wait immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // While reset is held the pipeline is frozen and filled with bubbles.
    assign pc_en              = w_pc_en & ~rst;
    assign pc_redirect        = w_redirect & ~rst;
    assign if_id_en           = w_if_id_en & ~rst;
    assign id_ex_en           = w_id_ex_en & ~rst;
    assign ex_mem_en          = w_ex_mem_en & ~rst;
    assign if_id_flush        = w_if_id_flush | rst;
    assign id_ex_flush        = w_id_ex_flush | rst;
    assign pc_redirect_target = pc_rollback_ex_o;
    assign stall_cnt          = r_stall_cnt;
    assign flush_cnt          = r_flush_cnt;
    assign state_o            = r_state;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the stall and flush event counters.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PL_stall  in  1  load-use hazard request from the EX stage forward unit.
REQ-005 SHALL have port PL_flush  in  1  branch/jalr mispredict indication from EX.
REQ-006 SHALL have port pc_rollback_ex_o  in  32  corrected PC from EX, valid while PL_flush=1.
REQ-007 SHALL have port md_req  in  1  EX holds a multicycle (mul/div) op; level signal.
REQ-008 SHALL have port md_done  in  1  one-cycle pulse; the multicycle result is ready.
REQ-009 SHALL have port pc_en  out  1  PC register write enable.
REQ-010 SHALL have port pc_redirect  out  1  PC mux selects pc_redirect_target.
REQ-011 SHALL have port pc_redirect_target  out  32  redirect PC.
REQ-012 SHALL have ports if_id_en, id_ex_en, ex_mem_en  out  1 each  pipeline register enables.
REQ-013 SHALL have ports if_id_flush, id_ex_flush  out  1 each  synchronous bubble insert into the next register.
REQ-014 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  event counters.
REQ-015 SHALL have port state_o  out  2  current FSM state encoding.

Function
REQ-016 SHALL implement FSM states RUN=2'd0, RECOVER=2'd1, MD_WAIT=2'd2; 2'd3 is illegal and SHALL return to RUN on the next edge with RUN outputs.
REQ-017 In RUN with PL_flush=1, the block SHALL assert, combinationally in the same cycle:
- pc_redirect=1, pc_redirect_target=pc_rollback_ex_o, pc_en=1
- if_id_flush=1, id_ex_flush=1, ex_mem_en=1
- next state RECOVER.
REQ-018 PL_flush SHALL have priority over PL_stall and md_req in the same cycle; the stall and md requests are discarded because their instructions are squashed.
REQ-019 In RUN with PL_stall=1 and PL_flush=0, the block SHALL drive pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 and ex_mem_en=1, and SHALL stay in RUN.
REQ-020 In RUN with md_req=1, PL_flush=0 and PL_stall=0, the block SHALL drive pc_en=0, if_id_en=0, id_ex_en=0 and ex_mem_en=0, with next state MD_WAIT.
REQ-021 In RUN with no request, all enables SHALL be 1, all flushes 0 and pc_redirect=0.
REQ-022 RECOVER SHALL last exactly 1 cycle, covering the synchronous instruction-memory latency:
- pc_en=1, if_id_flush=1, other enables 1, pc_redirect=0
- PL_stall, PL_flush and md_req ignored
- next state RUN.
REQ-023 MD_WAIT SHALL hold pc_en, if_id_en, id_ex_en and ex_mem_en at 0 until md_done=1.
- In the md_done cycle: ex_mem_en=1, id_ex_flush=1, pc_en=0, if_id_en=0; next state RUN.
- PL_flush and PL_stall SHALL be ignored in MD_WAIT.
REQ-024 stall_cnt SHALL increment by 1 on every edge where REQ-019 or MD_WAIT hold applies, and SHALL saturate at all-ones.
REQ-025 flush_cnt SHALL increment by 1 on every REQ-017 event, and SHALL saturate at all-ones.
REQ-026 md_done outside MD_WAIT SHALL have no effect.
REQ-027 pc_redirect_target SHALL equal pc_rollback_ex_o whenever pc_redirect=0 (pass-through, no register).

Reset
REQ-028 While rst=1, the block SHALL force, regardless of inputs:
- state RUN, counters 0
- pc_en, if_id_en, id_ex_en and ex_mem_en = 0
- if_id_flush = 1, id_ex_flush = 1, pc_redirect = 0.
REQ-029 An assertion of rst mid-MD_WAIT or mid-RECOVER SHALL abort the operation immediately (asynchronously); the first cycle after release SHALL be RUN with no residual hold.

Verification
REQ-030 Reset release, no requests -> all enables 1, flushes 0, state_o=0, counters 0.
REQ-031 PL_flush=1, pc_rollback_ex_o=32'h0000_0124 for 1 cycle -> same cycle pc_redirect=1, target=32'h124, if_id_flush=id_ex_flush=1; next cycle state_o=1, if_id_flush=1; following cycle state_o=0; flush_cnt=1.
REQ-032 PL_stall=1 for 2 cycles -> pc_en=if_id_en=0 and id_ex_flush=1 for both cycles; stall_cnt=2.
REQ-033 md_req=1, md_done pulsed 5 cycles later -> 5 cycles with all enables 0, then 1 cycle with ex_mem_en=1 and id_ex_flush=1, then RUN; stall_cnt=6.
REQ-034 PL_flush=1 and PL_stall=1 and md_req=1 in the same cycle -> flush behaviour only, next state RECOVER, stall_cnt unchanged.
REQ-035 CNT_W=4, 20 consecutive stall cycles -> stall_cnt=4'hF; rst asserted during MD_WAIT -> state_o=0 immediately, outputs at reset values.
